micron_psram_responder: RTL and testbench
=========================================

Name: micron_psram_responder

Overview:
- Synthesizable device-side model of the Micron CellularRAM synchronous burst interface; the memory end of the bus that micron_controller drives.
- Allows controller bring-up on FPGA without the external part, and serves as a cycle-accurate responder in controller benches.
- Backed by a register array. The data bus is split (data_in/data_out/data_oe); benches and top levels add the tristate on mdata.

Parameters:
- NUM_ELEMENTS, 8, words of storage; power of 2; address taken modulo NUM_ELEMENTS.
- LATENCY, 3, clock edges from address capture to first data transfer; minimum 2.
- BCR_RESET, 16'h9D1F, reset value of the bus configuration register.

Ports:
- clk  in  1  device clock; the controller's mclk.
- rst_L  in  1  synchronous reset, active low.
- addr  in  23  word address; maddr[22:0].
- adv_L  in  1  address valid, active low.
- ce_L  in  1  chip enable, active low.
- oe_L  in  1  output enable, active low.
- we_L  in  1  write enable, active low; sampled with adv_L.
- ub_L  in  1  upper byte enable, active low; applies to bits 15:8.
- lb_L  in  1  lower byte enable, active low; applies to bits 7:0.
- cre  in  1  configuration register access; sampled with adv_L.
- data_in  in  16  write data from controller.
- data_out  out  16  read data, registered.
- data_oe  out  1  drive enable for mdata.
- mem_wait  out  1  WAIT, active high, registered.

Behaviour:
- Reset (rst_L=0 at a rising edge), from any state, mid-burst included:
  - state IDLE; mem_wait 0; data_out 0; BCR=BCR_RESET.
  - Array contents are not reset.
- States: IDLE, LAT, WR, RD.
- E0 is the edge where ce_L=0 and adv_L=0. In any state this captures ptr=addr mod NUM_ELEMENTS, wr=~we_L and cfg=cre.
- E0 with cfg=1 and wr=1: BCR<=addr[15:0]; next state IDLE; no data phase.
- Otherwise at E0: mem_wait<=1, cnt<=LATENCY-1, next state LAT.
- LAT: cnt decrements each edge.
  - At the edge where cnt reaches 1, mem_wait<=0.
  - For a read, at that same edge data_out<=mem[ptr] (or BCR if cfg); next state RD.
  - For a write, the next state is WR at the edge where cnt reaches 1.
- WR: at edges E0+LATENCY, E0+LATENCY+1, and so on, each edge:
  - mem[ptr][15:8]<=data_in[15:8] if ub_L=0.
  - mem[ptr][7:0]<=data_in[7:0] if lb_L=0.
  - ptr<=ptr+1 mod NUM_ELEMENTS.
  - Both byte enables high: no array change, ptr still advances.
- RD: the controller samples data_out at E0+LATENCY and each following edge. Each edge in RD: ptr<=ptr+1 and data_out<=mem[ptr+1].
  - Config read returns BCR on every beat; ptr is unused.
- Burst is continuous and wraps: ptr NUM_ELEMENTS-1 -> 0.
- data_oe = ~ce_L & ~oe_L & (state==RD). Combinational; never 1 in IDLE, LAT or WR.
- ce_L=1 at any edge: next state IDLE, mem_wait<=0, no write at that edge. data_out holds its value.
- adv_L=0 with ce_L=0 during LAT/WR/RD: aborts the burst and restarts from the new E0. No write occurs at that edge.
- oe_L is ignored for state progression; it gates data_oe only.
- A write to the same address as a pending read is visible on a later read burst only; no intra-burst forwarding is required.

Test Plan:
- Write burst, LATENCY=3: E0 addr=2, we_L=0; data_in 16'hA1A1, B2B2, C3C3 at E0+3..E0+5 with ub_L=lb_L=0, then ce_L=1 -> mem[2..4]=A1A1,B2B2,C3C3; mem_wait 1 for edges E0..E0+1, 0 after E0+2.
- Read burst of those words: E0 addr=2, we_L=1, oe_L=0 -> data_out A1A1, B2B2, C3C3 sampled at E0+3..E0+5; data_oe 1 from E0+2 until ce_L rises.
- Wrap and byte enables: write at addr=7 with two beats 16'h1234 (lb_L=1), 16'h5678 (ub_L=1) -> mem[7][15:8]=8'h12, mem[0][7:0]=8'h78, other bytes unchanged; read-back at addr=7 returns those values.
- Config: cre=1, we_L=0, addr=16'h8010 at E0 -> BCR=8010, state IDLE. Then a cre=1 read -> data_out 16'h8010 at E0+3 and E0+4.
- Abort/restart: during a read at addr=0, assert adv_L=0 with addr=5 at E0+4 -> mem_wait 1 again; first beat mem[5] sampled at E0+7.
- Reset mid-write: rst_L=0 at E0+4 of a write burst -> no write at that edge; mem_wait=0, data_oe=0, data_out=0, BCR=9D1F; the word written at E0+3 is kept.

Source files
------------

// File: rtl/micron_psram_responder.sv
// micron_psram_responder: device-side CellularRAM synchronous burst model backed by a register array
module micron_psram_responder #(
  parameter int          NUM_ELEMENTS = 8,
  parameter int          LATENCY      = 3,
  parameter logic [15:0] BCR_RESET    = 16'h9D1F
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic [22:0] addr,
  input  logic        adv_L,
  input  logic        ce_L,
  input  logic        oe_L,
  input  logic        we_L,
  input  logic        ub_L,
  input  logic        lb_L,
  input  logic        cre,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        mem_wait
);
  localparam int AW = NUM_ELEMENTS > 1 ? $clog2(NUM_ELEMENTS) : 1;
  localparam int CW = $clog2(LATENCY);
  typedef enum logic [1:0] {IDLE, LAT, WR, RD} state_t;
  state_t state, state_next;
  logic [15:0] mem [NUM_ELEMENTS];
  logic [15:0] bcr;
  logic [AW-1:0] ptr, ptr_inc;
  logic [CW-1:0] cnt;
  logic wr, cfg, e0, cfg_wr, lat_done, wr_beat;
  assign e0       = ~ce_L & ~adv_L;
  assign cfg_wr   = e0 & cre & ~we_L;
  assign lat_done = (state == LAT) && (cnt == CW'(1));
  assign wr_beat  = ~ce_L & adv_L & (state == WR);
  assign ptr_inc  = ptr + AW'(1);
  assign data_oe  = ~ce_L & ~oe_L & (state == RD);
  // Next state: deselect dominates, a new address phase restarts, latency expiry enters the data phase
  always_comb begin
    state_next = state;
    if (ce_L) state_next = IDLE;
    else if (!adv_L) state_next = cfg_wr ? IDLE : LAT;
    else if (lat_done) state_next = wr ? WR : RD;
  end
  // State register, burst pointer, latency counter, WAIT, read data and BCR
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state    <= IDLE;
      mem_wait <= 1'b0;
      data_out <= '0;
      bcr      <= BCR_RESET;
      ptr      <= '0;
      cnt      <= '0;
      wr       <= 1'b0;
      cfg      <= 1'b0;
    end else begin
      state <= state_next;
      if (ce_L) mem_wait <= 1'b0;
      else if (e0) begin
        ptr      <= addr[AW-1:0];
        wr       <= ~we_L;
        cfg      <= cre;
        cnt      <= CW'(LATENCY - 1);
        mem_wait <= ~cfg_wr;
        if (cfg_wr) bcr <= addr[15:0];
      end else if (state == LAT) begin
        cnt <= cnt - CW'(1);
        if (lat_done) begin
          mem_wait <= 1'b0;
          if (!wr) data_out <= cfg ? bcr : mem[ptr];
        end
      end else if (state == WR) ptr <= ptr_inc;
      else if (state == RD) begin
        ptr      <= ptr_inc;
        data_out <= cfg ? bcr : mem[ptr_inc];
      end
    end
  end
  // Array write with per-byte enables; contents survive reset but no write lands on a reset edge
  always_ff @(posedge clk) begin
    if (rst_L && wr_beat) begin
      if (!ub_L) mem[ptr][15:8] <= data_in[15:8];
      if (!lb_L) mem[ptr][7:0] <= data_in[7:0];
    end
  end
endmodule

// File: tb/tb_micron_psram_responder.sv
// tb_micron_psram_responder: table-driven and directed checks of the PSRAM responder
module tb_micron_psram_responder;
  logic clk = 1'b0, rst_L = 1'b0;
  logic [22:0] addr = '0;
  logic adv_L = 1'b1, ce_L = 1'b1, oe_L = 1'b1, we_L = 1'b1, ub_L = 1'b1, lb_L = 1'b1, cre = 1'b0;
  logic [15:0] data_in = '0, data_out;
  logic data_oe, mem_wait;
  int checks = 0, errors = 0;
  typedef struct {
    logic ce, adv, oe, we, ub, lb, cr;
    logic [22:0] a;
    logic [15:0] d;
    logic cd;
    logic [15:0] eq;
    logic ew, eoe;
  } vec_t;
  vec_t vq[$];
  micron_psram_responder dut (
    .clk(clk), .rst_L(rst_L), .addr(addr), .adv_L(adv_L), .ce_L(ce_L), .oe_L(oe_L),
    .we_L(we_L), .ub_L(ub_L), .lb_L(lb_L), .cre(cre), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .mem_wait(mem_wait)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic ce, adv, oe, we, ub, lb, cr, input logic [22:0] a,
                              input logic [15:0] d, input logic cd, input logic [15:0] eq,
                              input logic ew, eoe);
    vec_t v;
    v.ce = ce; v.adv = adv; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb; v.cr = cr;
    v.a = a; v.d = d; v.cd = cd; v.eq = eq; v.ew = ew; v.eoe = eoe;
    return v;
  endfunction
  task automatic step(input logic ce, adv, oe, we, ub, lb, cr, input logic [22:0] a, input logic [15:0] d);
    ce_L = ce; adv_L = adv; oe_L = oe; we_L = we; ub_L = ub; lb_L = lb; cre = cr; addr = a; data_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic idle();
    step(1, 1, 1, 1, 1, 1, 0, 0, 0);
  endtask
  initial begin
    // fill mem[7]=7070, mem[0]=0A0B via a wrapping write burst
    vq.push_back(mk(0,0,1,0,1,1,0,7,0,          0,0,1,0));
    vq.push_back(mk(0,1,1,1,1,1,0,0,0,          0,0,1,0));
    vq.push_back(mk(0,1,1,1,1,1,0,0,0,          0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0,0,0,16'h7070,   0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0,0,0,16'h0A0B,   0,0,0,0));
    vq.push_back(mk(1,1,1,1,1,1,0,0,0,          0,0,0,0));
    // write burst at 2: A1A1 B2B2 C3C3 D4D4
    vq.push_back(mk(0,0,1,0,1,1,0,2,0,          0,0,1,0));
    vq.push_back(mk(0,1,1,1,1,1,0,0,0,          0,0,1,0));
    vq.push_back(mk(0,1,1,1,1,1,0,0,0,          0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0,0,0,16'hA1A1,   0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0,0,0,16'hB2B2,   0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0,0,0,16'hC3C3,   0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0,0,0,16'hD4D4,   0,0,0,0));
    vq.push_back(mk(1,1,1,1,1,1,0,0,0,          0,0,0,0));
    // read burst at 2, then deselect holds data_out
    vq.push_back(mk(0,0,0,1,1,1,0,2,0,          0,0,1,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          0,0,1,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          1,16'hA1A1,0,1));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          1,16'hB2B2,0,1));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          1,16'hC3C3,0,1));
    vq.push_back(mk(1,1,1,1,1,1,0,0,0,          1,16'hC3C3,0,0));
    // byte-enable write at 7 wrapping to 0
    vq.push_back(mk(0,0,1,0,1,1,0,7,0,          0,0,1,0));
    vq.push_back(mk(0,1,1,1,1,1,0,0,0,          0,0,1,0));
    vq.push_back(mk(0,1,1,1,1,1,0,0,0,          0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,1,0,0,16'h1234,   0,0,0,0));
    vq.push_back(mk(0,1,1,1,1,0,0,0,16'h5678,   0,0,0,0));
    vq.push_back(mk(1,1,1,1,1,1,0,0,0,          0,0,0,0));
    // read back at 7
    vq.push_back(mk(0,0,0,1,1,1,0,7,0,          0,0,1,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          0,0,1,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          1,16'h1270,0,1));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          1,16'h0A78,0,1));
    vq.push_back(mk(1,1,1,1,1,1,0,0,0,          1,16'h0A78,0,0));
    // config write BCR=8010, stays IDLE with no data phase
    vq.push_back(mk(0,0,1,0,1,1,1,23'h8010,0,   0,0,0,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          0,0,0,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          0,0,0,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          0,0,0,0));
    vq.push_back(mk(1,1,1,1,1,1,0,0,0,          0,0,0,0));
    // config read returns BCR on every beat
    vq.push_back(mk(0,0,0,1,1,1,1,0,0,          0,0,1,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          0,0,1,0));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          1,16'h8010,0,1));
    vq.push_back(mk(0,1,0,1,1,1,0,0,0,          1,16'h8010,0,1));
    vq.push_back(mk(1,1,1,1,1,1,0,0,0,          1,16'h8010,0,0));
    // reset state
    idle();
    idle();
    chk("reset data_out", data_out, 16'h0);
    chk("reset wait", {15'b0, mem_wait}, 16'h0);
    chk("reset oe", {15'b0, data_oe}, 16'h0);
    rst_L = 1'b1;
    idle();
    foreach (vq[i]) begin
      step(vq[i].ce, vq[i].adv, vq[i].oe, vq[i].we, vq[i].ub, vq[i].lb, vq[i].cr, vq[i].a, vq[i].d);
      chk($sformatf("vec%0d wait", i), {15'b0, mem_wait}, {15'b0, vq[i].ew});
      chk($sformatf("vec%0d oe", i), {15'b0, data_oe}, {15'b0, vq[i].eoe});
      if (vq[i].cd) chk($sformatf("vec%0d data", i), data_out, vq[i].eq);
    end
    // abort a read at 0 with a new address phase at 5
    step(0, 0, 0, 1, 1, 1, 0, 0, 0);
    chk("abort e0 wait", {15'b0, mem_wait}, 16'h1);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("abort beat0 data", data_out, 16'h0A78);
    chk("abort beat0 oe", {15'b0, data_oe}, 16'h1);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 5, 0);
    chk("restart wait", {15'b0, mem_wait}, 16'h1);
    chk("restart oe", {15'b0, data_oe}, 16'h0);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("restart lat wait", {15'b0, mem_wait}, 16'h1);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("restart beat data", data_out, 16'hD4D4);
    chk("restart beat wait", {15'b0, mem_wait}, 16'h0);
    idle();
    chk("restart hold data", data_out, 16'hD4D4);
    // reset in the middle of a write burst at 6
    step(0, 0, 1, 0, 1, 1, 0, 6, 0);
    step(0, 1, 1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 16'h6666);
    rst_L = 1'b0;
    step(0, 1, 0, 1, 0, 0, 0, 0, 16'h7777);
    chk("midrst wait", {15'b0, mem_wait}, 16'h0);
    chk("midrst oe", {15'b0, data_oe}, 16'h0);
    chk("midrst data", data_out, 16'h0);
    rst_L = 1'b1;
    idle();
    step(0, 0, 0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("bcr after reset", data_out, 16'h9D1F);
    idle();
    step(0, 0, 0, 1, 1, 1, 0, 6, 0);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("kept word 6", data_out, 16'h6666);
    step(0, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("no write 7", data_out, 16'h1270);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
